// File: rtl/code_lock_pkg.sv
// Shared types and constants for the colour-code lock front end.
package code_lock_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  localparam int START = 0;
  localparam int RED   = 1;
  localparam int GREEN = 2;
  localparam int BLUE  = 3;
endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Raw button inputs and conditioned press pulses between the buttons and the code detector.
interface button_pulse_conditioner_if;
  logic Start_btn;
  logic Red_btn;
  logic Green_btn;
  logic Blue_btn;
  logic Start;
  logic Red;
  logic Green;
  logic Blue;
  logic Any_held;

  modport master (
    output Start_btn, Red_btn, Green_btn, Blue_btn,
    input  Start, Red, Green, Blue, Any_held
  );

  modport slave (
    input  Start_btn, Red_btn, Green_btn, Blue_btn,
    output Start, Red, Green, Blue, Any_held
  );
endinterface

// File: rtl/button_debounce.sv
// One button: two-flop synchroniser, stability counter and press/release FSM.
module button_debounce
  import code_lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn_raw,
  output logic press_pulse,
  output logic held
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          press_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        // A release bounce returns to PRESSED silently: the press was already reported.
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign held = (state_q == PRESSED) || (state_q == REL_WAIT);
endmodule

// File: rtl/button_pulse_conditioner.sv
// Four debounced buttons -> registered one-cycle press pulses; Start masks colours in the same cycle.
module button_pulse_conditioner
  import code_lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  button_pulse_conditioner_if.slave     bus
);
  logic [3:0] btn_raw;
  logic [3:0] raw_pulse;
  logic [3:0] held;
  logic [3:0] pulse_q, pulse_d;
  logic       any_held_q, any_held_d;

  assign btn_raw[START] = bus.Start_btn;
  assign btn_raw[RED]   = bus.Red_btn;
  assign btn_raw[GREEN] = bus.Green_btn;
  assign btn_raw[BLUE]  = bus.Blue_btn;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .Clk         (Clk),
      .Rst         (Rst),
      .btn_raw     (btn_raw[i]),
      .press_pulse (raw_pulse[i]),
      .held        (held[i])
    );
  end

  always_comb begin
    pulse_d        = raw_pulse & {4{~raw_pulse[START]}};
    pulse_d[START] = raw_pulse[START];
    any_held_d     = |held;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pulse_q    <= '0;
      any_held_q <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      any_held_q <= any_held_d;
    end
  end

  assign bus.Start    = pulse_q[START];
  assign bus.Red      = pulse_q[RED];
  assign bus.Green    = pulse_q[GREEN];
  assign bus.Blue     = pulse_q[BLUE];
  assign bus.Any_held = any_held_q;
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses {mask, edge}; a monitor pops on every output pulse.
module tb_button_pulse_conditioner;
  localparam int D = 4;

  typedef struct {
    logic [3:0] mask;  // {Blue, Green, Red, Start}
    int         cyc;
  } exp_t;

  logic Clk;
  logic Rst;
  int   cyc;
  int   tests;
  int   failed;
  exp_t exp_q[$];

  button_pulse_conditioner_if bus_if ();

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_if.slave)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 5 ns after each edge; cyc then equals the index of that edge.
  always @(posedge Clk) begin
    logic [3:0] obs;
    exp_t       e;
    #5;
    obs = {bus_if.Blue, bus_if.Green, bus_if.Red, bus_if.Start};
    if (obs != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(obs), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_mask", int'(obs), int'(e.mask));
        check("pulse_edge", cyc, e.cyc);
      end
    end
  end

  task automatic set_btn(input logic [3:0] b);
    bus_if.Start_btn = b[0];
    bus_if.Red_btn   = b[1];
    bus_if.Green_btn = b[2];
    bus_if.Blue_btn  = b[3];
  endtask

  // Leaves time 2 ns before the next edge.
  task automatic step();
    @(posedge Clk);
    #18;
  endtask

  // Leaves time 5 ns after edge n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge Clk);
      #1;
    end
    #4;
  endtask

  task automatic press(input logic [3:0] b, input logic [3:0] exp, input int hold, input int gap);
    step();
    set_btn(b);
    if (exp != 4'b0) exp_q.push_back('{exp, cyc + 1 + D + 2});
    repeat (hold) step();
    set_btn(4'b0);
    repeat (gap) step();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int e0;
    int k;
    tests  = 0;
    failed = 0;
    Rst    = 1'b0;
    set_btn(4'b0);

    // Reset state
    wait_cyc(3);
    check("rst_start", int'(bus_if.Start), 0);
    check("rst_red", int'(bus_if.Red), 0);
    check("rst_green", int'(bus_if.Green), 0);
    check("rst_blue", int'(bus_if.Blue), 0);
    check("rst_any_held", int'(bus_if.Any_held), 0);
    Rst = 1'b1;
    repeat (3) step();

    // Clean Red press held 20 cycles
    step();
    set_btn(4'b0010);
    e0 = cyc + 1;
    exp_q.push_back('{4'b0010, e0 + D + 2});
    wait_cyc(e0 + D + 2);
    check("held_before", int'(bus_if.Any_held), 0);
    wait_cyc(e0 + D + 3);
    check("held_after", int'(bus_if.Any_held), 1);
    while (cyc < e0 + 19) step();
    set_btn(4'b0);
    k = cyc;
    wait_cyc(k + D + 3);
    check("held_rel_wait", int'(bus_if.Any_held), 1);
    wait_cyc(k + D + 4);
    check("held_released", int'(bus_if.Any_held), 0);
    repeat (6) step();

    // Blue bouncing, then steady
    for (int i = 0; i < 6; i++) begin
      step();
      set_btn((i % 2 == 0) ? 4'b1000 : 4'b0000);
    end
    press(4'b1000, 4'b1000, 14, 12);

    // Green shorter than the debounce window
    step();
    set_btn(4'b0100);
    step();
    step();
    set_btn(4'b0);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(cyc + 1);
      check("green_short_held", int'(bus_if.Any_held), 0);
    end

    // Start and Red on the same edge
    press(4'b0011, 4'b0001, 12, 12);

    // Full code: Start, Red, Blue, Green, Red
    press(4'b0001, 4'b0001, 9, 12);
    press(4'b0010, 4'b0010, 9, 12);
    press(4'b1000, 4'b1000, 9, 12);
    press(4'b0100, 4'b0100, 9, 12);
    press(4'b0010, 4'b0010, 9, 12);

    // Reset mid-PRESS_WAIT with Red held
    step();
    set_btn(4'b0010);
    e0 = cyc + 1;
    wait_cyc(e0 + 4);
    Rst = 1'b0;
    #1;
    check("rst_mid_red", int'(bus_if.Red), 0);
    check("rst_mid_start", int'(bus_if.Start), 0);
    check("rst_mid_any_held", int'(bus_if.Any_held), 0);
    wait_cyc(cyc + 3);
    Rst = 1'b1;
    k = cyc;
    exp_q.push_back('{4'b0010, k + 1 + D + 2});
    wait_cyc(k + D + 8);
    check("rst_rel_held", int'(bus_if.Any_held), 1);
    step();
    set_btn(4'b0);
    repeat (20) step();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
